// File: rtl/ccff_cfg_pkg.sv
// Shared definitions for the ccff chain loader.
//   ldr_state_e       : loader FSM states (IDLE, SHIFT, DONE)
//   *_CHAIN_LEN       : ccff chain lengths of the connection blocks
//   DEFAULT_WORD_W    : default config/readback word width
//   nwords(len, w)    : number of w-bit words needed to cover len bits
package ccff_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ldr_state_e;

  // cbx_1__0: 7 size6 muxes (3 mem bits each) + 1 size2 mux (2 mem bits).
  localparam int CBX_1__0_CHAIN_LEN = 23;
  localparam int CBY_0__1_CHAIN_LEN = 23;

  localparam int DEFAULT_WORD_W = 8;

  // ceil(len / w)
  function automatic int nwords(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-word packer for chain readback.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   capture_en  : bit_in is taken this cycle
//   bit_in      : serial bit (first captured bit lands in rb_data[0])
//   flush       : this capture is the last of the load; emit a partial word
//   rb_data     : packed word, held until the next word completes
//   rb_valid    : 1-cycle pulse the cycle after a word completes
module ccff_rb_packer
  #(parameter int W = 8)
  (
    input  logic         clk,
    input  logic         reset,
    input  logic         capture_en,
    input  logic         bit_in,
    input  logic         flush,
    output logic [W-1:0] rb_data,
    output logic         rb_valid
  );

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(W - 1);

  logic [W-1:0]  acc_q;
  logic [W-1:0]  acc_d;
  logic [IW-1:0] idx_q;
  logic          word_end;

  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = bit_in;
  end

  assign word_end = capture_en && (flush || (idx_q == TOP_IDX));

  // The accumulator is cleared after every emitted word, so a partial final
  // word carries zeros in its unused upper bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      idx_q    <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= word_end;
      if (capture_en) begin
        if (word_end) begin
          rb_data <= acc_d;
          acc_q   <= '0;
          idx_q   <= '0;
        end else begin
          acc_q <= acc_d;
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads one ccff configuration chain and reads back its previous contents.
// Ports:
//   prog_clk, prog_reset : clock, synchronous active-high reset
//   start                : pulse; begins a load when idle
//   cfg_data/cfg_valid/cfg_ready : config word stream, bit 0 shifted first
//   ccff_head            : serial bit into the chain
//   ccff_shift_en        : chain advances on the next prog_clk edge
//   ccff_tail            : serial bit out of the chain
//   rb_data/rb_valid     : readback words, bit 0 = first captured bit
//   busy                 : high while shifting
//   done                 : 1-cycle pulse at load completion
//   state                : current FSM state (ldr_state_e encoding)
//
// Handshake: a config word transfers on a rising edge where cfg_valid and
// cfg_ready are both 1; cfg_ready does not depend on cfg_valid, and the host
// must hold cfg_data stable while cfg_valid is 1 and cfg_ready is 0.
// rb_valid has no backpressure.
module ccff_chain_loader
  import ccff_cfg_pkg::*;
  #(
    parameter int CHAIN_LEN = CBX_1__0_CHAIN_LEN,
    parameter int W         = DEFAULT_WORD_W
  )
  (
    input  logic         prog_clk,
    input  logic         prog_reset,
    input  logic         start,
    input  logic [W-1:0] cfg_data,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    output logic         ccff_head,
    output logic         ccff_shift_en,
    input  logic         ccff_tail,
    output logic [W-1:0] rb_data,
    output logic         rb_valid,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state
  );

  localparam int NWORDS = nwords(CHAIN_LEN, W);
  localparam int CW     = $clog2(CHAIN_LEN + 1);
  localparam int SCW    = $clog2(W + 1);
  localparam int NCW    = $clog2(NWORDS + 1);

  localparam logic [CW-1:0]  LEN_C    = CW'(CHAIN_LEN);
  localparam logic [CW-1:0]  LAST_IDX = CW'(CHAIN_LEN - 1);
  localparam logic [SCW-1:0] FULL_CNT = SCW'(W);
  localparam logic [NCW-1:0] NWORDS_C = NCW'(NWORDS);

  ldr_state_e     cur_state;
  ldr_state_e     nxt_state;

  logic [W-1:0]   sr_q, sr_d;          // shift register, bit 0 is next out
  logic [SCW-1:0] sr_cnt_q, sr_cnt_d;  // valid bits left in sr_q
  logic [W-1:0]   hr_q, hr_d;          // holding register
  logic           hr_full_q, hr_full_d;
  logic [CW-1:0]  bits_q, bits_d;      // bits shifted this load
  logic [NCW-1:0] words_q, words_d;    // words accepted this load

  logic in_shift;
  logic accept;
  logic last_bit;

  assign in_shift      = (cur_state == SHIFT);
  assign cfg_ready     = in_shift && !hr_full_q && (words_q < NWORDS_C);
  assign accept        = cfg_valid && cfg_ready;
  assign ccff_shift_en = in_shift && (sr_cnt_q != '0) && (bits_q < LEN_C);
  assign ccff_head     = ccff_shift_en & sr_q[0];
  assign last_bit      = ccff_shift_en && (bits_q == LAST_IDX);
  assign busy          = in_shift;
  assign done          = (cur_state == DONE);
  assign state         = cur_state;

  // FSM next state
  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      IDLE:    if (start) nxt_state = SHIFT;
      SHIFT:   if (last_bit) nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Datapath next state. Outside SHIFT all bookkeeping is cleared so every
  // load starts from bit 0 with empty buffers.
  always_comb begin
    sr_d      = sr_q;
    sr_cnt_d  = sr_cnt_q;
    hr_d      = hr_q;
    hr_full_d = hr_full_q;
    bits_d    = bits_q;
    words_d   = words_q;
    if (!in_shift) begin
      sr_cnt_d  = '0;
      hr_full_d = 1'b0;
      bits_d    = '0;
      words_d   = '0;
    end else begin
      if (ccff_shift_en) begin
        sr_d     = sr_q >> 1;
        sr_cnt_d = sr_cnt_q - SCW'(1);
        bits_d   = bits_q + CW'(1);
      end
      if (accept) begin
        words_d = words_q + NCW'(1);
      end
      // When the SR empties on this edge it is refilled at once (from HR
      // first, otherwise straight from the host), so no bubble appears
      // between words. Unused upper bits of the last word are never shifted
      // because the bit counter stops the load.
      if (sr_cnt_d == '0) begin
        if (hr_full_q) begin
          sr_d      = hr_q;
          sr_cnt_d  = FULL_CNT;
          hr_full_d = 1'b0;
        end else if (accept) begin
          sr_d     = cfg_data;
          sr_cnt_d = FULL_CNT;
        end
      end else if (accept) begin
        hr_d      = cfg_data;
        hr_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cur_state <= IDLE;
      sr_q      <= '0;
      sr_cnt_q  <= '0;
      hr_q      <= '0;
      hr_full_q <= 1'b0;
      bits_q    <= '0;
      words_q   <= '0;
    end else begin
      cur_state <= nxt_state;
      sr_q      <= sr_d;
      sr_cnt_q  <= sr_cnt_d;
      hr_q      <= hr_d;
      hr_full_q <= hr_full_d;
      bits_q    <= bits_d;
      words_q   <= words_d;
    end
  end

  // Captures the tail bit leaving the chain on each shift; the last shifted
  // bit flushes the partial final word so it lines up with done.
  ccff_rb_packer #(.W(W)) u_packer (
    .clk        (prog_clk),
    .reset      (prog_reset),
    .capture_en (ccff_shift_en),
    .bit_in     (ccff_tail),
    .flush      (last_bit),
    .rb_data    (rb_data),
    .rb_valid   (rb_valid)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: physical chain model on head/tail, a per-cycle
// monitor against a spec-level model, and directed load scenarios.
module tb_ccff_chain_loader;
  import ccff_cfg_pkg::*;

  localparam int CHAIN_LEN = CBX_1__0_CHAIN_LEN;
  localparam int W         = 8;
  localparam int NWORDS    = nwords(CHAIN_LEN, W);

  // ---------------- clock / reset / DUT ----------------
  logic         prog_clk = 1'b0;
  logic         prog_reset;
  logic         start;
  logic [W-1:0] cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         ccff_head;
  logic         ccff_shift_en;
  logic         ccff_tail;
  logic [W-1:0] rb_data;
  logic         rb_valid;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cyc <= cyc + 1;

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .W(W)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .busy          (busy),
    .done          (done),
    .state         (state)
  );

  // ---------------- chain model ----------------
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] preload_val;
  logic                 preload_req;

  always @(posedge prog_clk) begin
    if (preload_req) chain <= preload_val;
    else if (ccff_shift_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
  end
  assign ccff_tail = chain[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic         exp_head_q[$];   // bits the chain must receive, in order
  logic [W-1:0] exp_q[$];        // readback words the loader must return
  logic [W-1:0] rb_seen[$];
  int   m_phase     = 0;          // 0 idle, 1 shifting, 2 done cycle
  int   shift_cnt   = 0;
  int   acc_cnt     = 0;
  int   first_shift = -1;
  int   last_shift  = -1;
  int   done_cyc    = -1;
  logic rb_due      = 1'b0;

  always @(negedge prog_clk) begin
    if (prog_reset) begin
      m_phase = 0;
      rb_due  = 1'b0;
      exp_head_q.delete();
      exp_q.delete();
    end else begin
      if (m_phase != 1 || acc_cnt >= NWORDS) check("ready_gate", cfg_ready, 0);
      if (cfg_valid && cfg_ready) acc_cnt++;
      check("busy", busy, m_phase == 1);
      check("done", done, m_phase == 2);
      check("rb_valid", rb_valid, rb_due);
      if (rb_valid) begin
        rb_seen.push_back(rb_data);
        check("rb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rb_data", rb_data, exp_q.pop_front());
      end
      rb_due = 1'b0;
      if (ccff_shift_en) begin
        check("shift_phase", m_phase, 1);
        check("head_avail", exp_head_q.size() != 0, 1);
        if (exp_head_q.size() != 0) check("head", ccff_head, exp_head_q.pop_front());
        if (shift_cnt == 0) first_shift = cyc;
        last_shift = cyc;
        shift_cnt++;
        if ((shift_cnt % W) == 0 || shift_cnt == CHAIN_LEN) rb_due = 1'b1;
      end else begin
        check("head_idle", ccff_head, 0);
      end
      if (done) begin
        done_cyc = cyc;
        check("rb_left", exp_q.size(), 0);
      end
      if (m_phase == 2) m_phase = 0;
      else if (m_phase == 1 && shift_cnt == CHAIN_LEN) m_phase = 2;
      else if (m_phase == 0 && start) m_phase = 1;
    end
  end

  // ---------------- driver tasks ----------------
  logic [W-1:0] words [NWORDS];
  int start_cyc;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic begin_load();
    logic [W-1:0] wv;
    exp_head_q.delete();
    exp_q.delete();
    rb_seen.delete();
    for (int b = 0; b < CHAIN_LEN; b++) exp_head_q.push_back(words[b / W][b % W]);
    for (int i = 0; i < NWORDS; i++) begin
      wv = '0;
      for (int j = 0; j < W; j++)
        if (i * W + j < CHAIN_LEN) wv[j] = chain[i * W + j];
      exp_q.push_back(wv);
    end
    shift_cnt   = 0;
    acc_cnt     = 0;
    first_shift = -1;
    last_shift  = -1;
    done_cyc    = -1;
    start       = 1'b1;
    start_cyc   = cyc;
    tick();
    start = 1'b0;
  endtask

  // gap: idle cycles before offering word 2; abort_at: bits shifted before
  // reset is pulsed (with start held high in the same cycle), -1 for none.
  task automatic run_load(input int gap, input int abort_at);
    int n_acc;
    int wait_cnt;
    bit fin;
    begin_load();
    n_acc    = 0;
    wait_cnt = 0;
    fin      = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (n_acc == 1 && wait_cnt < gap) begin
        cfg_valid = 1'b0;
        wait_cnt++;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = (n_acc < NWORDS) ? words[n_acc] : 8'hEE;
      end
      @(negedge prog_clk);
      #1;
      if (cfg_valid && cfg_ready) n_acc++;
      if (done) begin
        fin = 1;
      end else if (abort_at >= 0 && shift_cnt == abort_at) begin
        tick();
        cfg_valid  = 1'b0;
        prog_reset = 1'b1;
        start      = 1'b1;
        tick();
        prog_reset = 1'b0;
        start      = 1'b0;
        @(negedge prog_clk);
        #1;
        check("abort_shift_off", ccff_shift_en, 0);
        check("abort_state", state, IDLE);
        check("abort_rb_valid", rb_valid, 0);
        fin = 1;
      end
      tick();
    end
    cfg_valid = 1'b0;
    check("load_finished", fin, 1);
  endtask

  task automatic check_rb3(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c);
    check({name, "_rb_count"}, rb_seen.size(), 3);
    if (rb_seen.size() == 3) begin
      check({name, "_rb0"}, rb_seen[0], a);
      check({name, "_rb1"}, rb_seen[1], b);
      check({name, "_rb2"}, rb_seen[2], c);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    prog_reset  = 1'b1;
    start       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_data    = '0;
    preload_req = 1'b0;
    preload_val = '0;
    repeat (3) tick();
    @(negedge prog_clk);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_head", ccff_head, 0);
    check("rst_shift_en", ccff_shift_en, 0);
    check("rst_rb_valid", rb_valid, 0);
    check("rst_rb_data", rb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state, IDLE);
    tick();
    prog_reset = 1'b0;

    preload_val = 23'h5A1234;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
    tick();

    // Full zero-wait load, readback of preloaded contents.
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h7F;
    run_load(0, -1);
    check("t1_latency", done_cyc - start_cyc, CHAIN_LEN + 2);
    check("t1_first_shift", first_shift - start_cyc, 2);
    check("t1_contiguous", last_shift - first_shift + 1, CHAIN_LEN);
    check("t1_bits", shift_cnt, CHAIN_LEN);
    check("t1_words", acc_cnt, NWORDS);
    check_rb3("t1", 8'h34, 8'h12, 8'h5A);
    check("t1_chain", chain, 23'h7F3CA5);

    // Back-to-back: readback returns the previous load.
    run_load(0, -1);
    check("t2_latency", done_cyc - start_cyc, CHAIN_LEN + 2);
    check("t2_contiguous", last_shift - first_shift + 1, CHAIN_LEN);
    check_rb3("t2", 8'hA5, 8'h3C, 8'h7F);

    // Starvation: word 2 arrives 5 cycles after the SR runs dry.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    run_load(12, -1);
    check("t3_latency", done_cyc - start_cyc, CHAIN_LEN + 7);
    check("t3_span", last_shift - first_shift + 1, CHAIN_LEN + 5);
    check("t3_bits", shift_cnt, CHAIN_LEN);
    check("t3_words", acc_cnt, NWORDS);
    check_rb3("t3", 8'hA5, 8'h3C, 8'h7F);
    check("t3_chain", chain, 23'h332211);

    // Abort after 10 bits, then a fresh load.
    words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'h55;
    run_load(0, 10);
    words[0] = 8'hC3; words[1] = 8'h96; words[2] = 8'h69;
    run_load(0, -1);
    check("t4_latency", done_cyc - start_cyc, CHAIN_LEN + 2);
    check("t4_first_shift", first_shift - start_cyc, 2);
    check("t4_bits", shift_cnt, CHAIN_LEN);
    check("t4_rb_count", rb_seen.size(), NWORDS);
    check("t4_chain", chain, 23'h6996C3);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
